// File: rtl/shift_norm_pkg.sv
// Shared types and helpers for the sequential shift normalizer.
package shift_norm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic NORM_UNSIGNED = 1'b0;
    localparam logic NORM_SIGNED   = 1'b1;
    localparam int   STAGES        = 5;

    // Binary-search step size for stage idx: 16, 8, 4, 2, 1.
    function automatic logic [4:0] stage_k(input logic [2:0] idx);
        return 5'd16 >> idx;
    endfunction

endpackage

// File: rtl/norm_stage.sv
// One binary-search normalization step: shift left by k when the top bits are redundant.
module norm_stage
    import shift_norm_pkg::*;
(
    input  logic [31:0] work,
    input  logic [4:0]  k,
    input  logic        signed_mode,
    output logic [31:0] shifted,
    output logic        take
);

    logic [31:0] ones;
    logic [31:0] mask_u;
    logic [31:0] mask_s;
    logic [31:0] sign_xor;
    logic [5:0]  k_plus_1;

    assign ones     = '1;
    assign k_plus_1 = {1'b0, k} + 6'd1;
    assign mask_u   = ~(ones >> k);
    assign mask_s   = ~(ones >> k_plus_1);
    // Bits matching the sign become zero, so the signed test is a zero test on k+1 bits.
    assign sign_xor = work ^ {32{work[31]}};

    always_comb begin
        take = 1'b0;
        if (signed_mode == NORM_SIGNED) begin
            take = ((sign_xor & mask_s) == 32'h0);
        end else begin
            take = ((work & mask_u) == 32'h0);
        end
    end

    assign shifted = work << k;

endmodule

// File: rtl/shift_normalizer_32.sv
// Sequential normalizer: returns the left shift that normalizes a word (CLZ or redundant sign bits).
//
// state | meaning
// IDLE  | waiting for an input word (in_ready=1 once out of reset)
// RUN   | one binary-search stage per cycle, k = 16, 8, 4, 2, 1
// DONE  | result presented, waiting for out_ready
module shift_normalizer_32
    import shift_norm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_d,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_q,
    output logic [4:0]  out_shift_amt,
    output logic        out_zero
);

    state_t      state_r;
    state_t      state_next;
    logic [31:0] work_r;
    logic [4:0]  amt_r;
    logic [2:0]  idx_r;
    logic        signed_r;
    logic        zero_r;
    logic        in_ready_r;

    logic [4:0]  stage_amt;
    logic [31:0] stage_shifted;
    logic        stage_take;
    logic [31:0] work_next;
    logic [4:0]  amt_next;
    logic        accept;
    logic        last_stage;

    assign stage_amt = stage_k(idx_r);

    norm_stage u_norm_stage (
        .work        (work_r),
        .k           (stage_amt),
        .signed_mode (signed_r),
        .shifted     (stage_shifted),
        .take        (stage_take)
    );

    assign accept     = in_valid && in_ready_r;
    assign last_stage = (idx_r == 3'(STAGES - 1));
    assign work_next  = stage_take ? stage_shifted : work_r;
    assign amt_next   = stage_take ? (amt_r + stage_amt) : amt_r;

    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_stage) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            in_ready_r    <= 1'b0;
            work_r        <= 32'h0;
            amt_r         <= 5'd0;
            idx_r         <= 3'd0;
            signed_r      <= NORM_UNSIGNED;
            zero_r        <= 1'b0;
            out_q         <= 32'h0;
            out_shift_amt <= 5'd0;
            out_zero      <= 1'b0;
        end else begin
            state_r    <= state_next;
            // Registered so in_ready stays low through reset and rises on the first edge after it.
            in_ready_r <= (state_next == IDLE);
            case (state_r)
                IDLE: begin
                    if (accept) begin
                        work_r   <= in_d;
                        signed_r <= in_signed;
                        zero_r   <= (in_d == 32'h0);
                        amt_r    <= 5'd0;
                        idx_r    <= 3'd0;
                    end
                end
                RUN: begin
                    work_r <= work_next;
                    amt_r  <= amt_next;
                    idx_r  <= idx_r + 3'd1;
                    if (last_stage) begin
                        out_q         <= zero_r ? 32'h0 : work_next;
                        out_shift_amt <= zero_r ? 5'd0 : amt_next;
                        out_zero      <= zero_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = (state_r == DONE);

endmodule

// File: tb/tb_shift_normalizer_32.sv
// Directed-vector bench for shift_normalizer_32 with hand-computed expectations.
module tb_shift_normalizer_32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_d;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_q;
    logic [4:0]  out_shift_amt;
    logic        out_zero;

    int checks = 0;
    int errors = 0;

    shift_normalizer_32 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_d          (in_d),
        .in_signed     (in_signed),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_q         (out_q),
        .out_shift_amt (out_shift_amt),
        .out_zero      (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer a word, wait for acceptance, then count edges until out_valid (-1 on timeout).
    task automatic send(input logic [31:0] d, input logic s, output int lat);
        lat = -1;
        in_d      = d;
        in_signed = s;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_d      = 32'hA5A5A5A5;
        in_signed = ~s;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_q !== 32'h0 ||
            out_shift_amt !== 5'd0 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b q=%h amt=%0d z=%b, want all zero",
                     in_ready, out_valid, out_q, out_shift_amt, out_zero);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_unsigned_one();
        int lat;
        send(32'h00000001, 1'b0, lat);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL latency_u1: got %0d cycles, want 5", lat);
        end
        checks++;
        if (out_q !== 32'h80000000 || out_shift_amt !== 5'd31 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_one: q=%h amt=%0d z=%b, want 80000000/31/0",
                     out_q, out_shift_amt, out_zero);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop: out_valid=%b after handshake, want 0", out_valid);
        end
    endtask

    task automatic test_unsigned_mid();
        int lat;
        send(32'h00F00000, 1'b0, lat);
        checks++;
        if (out_q !== 32'hF0000000 || out_shift_amt !== 5'd8 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_mid: q=%h amt=%0d z=%b, want f0000000/8/0",
                     out_q, out_shift_amt, out_zero);
        end
        checks++;
        if ((out_q >> out_shift_amt) !== 32'h00F00000) begin
            errors++;
            $display("FAIL lsr_reconstruct: got %h, want 00f00000", out_q >> out_shift_amt);
        end
        consume();
    endtask

    task automatic test_signed();
        int lat;
        send(32'hFFFF8000, 1'b1, lat);
        checks++;
        if (out_q !== 32'h80000000 || out_shift_amt !== 5'd16 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL signed_ffff8000: q=%h amt=%0d z=%b, want 80000000/16/0",
                     out_q, out_shift_amt, out_zero);
        end
        consume();
        send(32'h00000FFF, 1'b1, lat);
        checks++;
        if (out_q !== 32'h7FF80000 || out_shift_amt !== 5'd19) begin
            errors++;
            $display("FAIL signed_00000fff: q=%h amt=%0d, want 7ff80000/19", out_q, out_shift_amt);
        end
        consume();
    endtask

    task automatic test_zero_and_ones();
        int lat;
        send(32'h00000000, 1'b1, lat);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL latency_zero: got %0d cycles, want 5", lat);
        end
        checks++;
        if (out_q !== 32'h0 || out_shift_amt !== 5'd0 || out_zero !== 1'b1) begin
            errors++;
            $display("FAIL signed_zero: q=%h amt=%0d z=%b, want 0/0/1", out_q, out_shift_amt, out_zero);
        end
        consume();
        send(32'hFFFFFFFF, 1'b1, lat);
        checks++;
        if (out_q !== 32'h80000000 || out_shift_amt !== 5'd31 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL signed_all_ones: q=%h amt=%0d z=%b, want 80000000/31/0",
                     out_q, out_shift_amt, out_zero);
        end
        consume();
        send(32'h00000000, 1'b0, lat);
        checks++;
        if (out_q !== 32'h0 || out_shift_amt !== 5'd0 || out_zero !== 1'b1) begin
            errors++;
            $display("FAIL unsigned_zero: q=%h amt=%0d z=%b, want 0/0/1", out_q, out_shift_amt, out_zero);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        send(32'h12345678, 1'b0, lat);
        in_valid  = 1'b1;
        in_d      = 32'hDEADBEEF;
        in_signed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_q !== 32'h91A2B3C0 || out_shift_amt !== 5'd3 ||
                in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: vld=%b q=%h amt=%0d rdy=%b, want 1/91a2b3c0/3/0",
                         i, out_valid, out_q, out_shift_amt, in_ready);
            end
        end
        in_valid = 1'b0;
        consume();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stray_result[%0d]: out_valid=%b, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_acc;
        int second_acc;
        int results;
        first_acc  = -1;
        second_acc = -1;
        results    = 0;
        in_d      = 32'h00F00000;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready && in_valid) begin
                if (first_acc < 0) first_acc = c;
                else if (second_acc < 0) second_acc = c;
            end
            if (out_valid) begin
                results++;
                checks++;
                if (out_q !== 32'hF0000000 || out_shift_amt !== 5'd8) begin
                    errors++;
                    $display("FAIL b2b_result: q=%h amt=%0d, want f0000000/8", out_q, out_shift_amt);
                end
            end
        end
        in_valid  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (second_acc - first_acc != 7 || first_acc < 0 || second_acc < 0) begin
            errors++;
            $display("FAIL b2b_interval: accepts at %0d and %0d, want 7 cycles apart", first_acc, second_acc);
        end
        checks++;
        if (results < 2) begin
            errors++;
            $display("FAIL b2b_count: %0d results, want at least 2", results);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        // Leave a non-zero result on the outputs so the reset clear is observable.
        send(32'h00000001, 1'b0, lat);
        consume();
        in_d      = 32'h0000FFFF;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_q !== 32'h0 ||
            out_shift_amt !== 5'd0 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset: rdy=%b vld=%b q=%h amt=%0d z=%b, want all zero",
                     in_ready, out_valid, out_q, out_shift_amt, out_zero);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_ready: in_ready=%b, want 1", in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL abandoned_result[%0d]: out_valid=%b, want 0", i, out_valid);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_d      = 32'h0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_unsigned_one();
        test_unsigned_mid();
        test_signed();
        test_zero_and_ones();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_normalizer_32.md
Name: shift_normalizer_32

Overview:
- Sequential inverse of barrel_shifter_32. It takes a 32-bit word and returns the left-shift amount that normalizes it, plus the normalized word.
- Two modes:
  - Unsigned: count leading zeros, so that q[31]=1.
  - Signed: count redundant sign bits, so that q[31]!=q[30].
- Results satisfy d = q LSR shift_amt (unsigned) or d = q ASR shift_amt (signed). This lets barrel_shifter_32 serve as the reconstruction checker.
- Sits in front of the shifter in the datapath, for FP-style normalization and CLZ instructions. Valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, data width; fixed at 32. Shift amount is $clog2(WIDTH)=5 bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word presented
- in_ready  out  1  block can accept a word
- in_d  in  32  word to normalize
- in_signed  in  1  0=unsigned (CLZ), 1=signed (redundant sign bits)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_q  out  32  normalized word
- out_shift_amt  out  5  left-shift amount applied
- out_zero  out  1  input was 32'h0

Behaviour:
- Clock and reset:
  - One clock domain.
  - rst_n low asynchronously forces state=IDLE, in_ready=0 during reset, out_valid=0, out_q=0, out_shift_amt=0, out_zero=0.
  - in_ready=1 from the first edge after reset is released.
- States: IDLE, RUN, DONE. Held in a 3-bit one-hot or 2-bit enum from the package.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge N: latch in_d, in_signed; clear the accumulator; step index=0; go to RUN.
- RUN:
  - in_ready=0.
  - One binary-search stage per cycle, with k = 16, 8, 4, 2, 1 at edges N+1 through N+5.
  - Unsigned: if the top k bits are all 0, then work <<= k and amt += k.
  - Signed: if the top k+1 bits all equal work[31], then work <<= k and amt += k.
  - After the k=1 stage (edge N+5), go to DONE.
- DONE:
  - out_valid=1 is visible after edge N+5, giving a fixed latency of 5 cycles from acceptance.
  - out_q, out_shift_amt and out_zero are held stable while out_valid && !out_ready.
  - On out_valid&&out_ready, go to IDLE; out_valid drops at that edge. Outputs keep their last values.
  - No overlap: a new word is accepted at the earliest one cycle after the result handshake. Throughput is one word per 7 cycles with out_ready tied high.
- Zero input (latched d == 0, either mode):
  - out_zero=1, out_q=0, out_shift_amt=0. This overrides the search result.
  - The zero case still takes the same 5-cycle latency.
- Signed all-ones (32'hFFFFFFFF):
  - out_zero=0, out_shift_amt=31, out_q=32'h80000000.
- Non-zero results:
  - Unsigned non-zero: out_q[31]=1 and out_shift_amt ranges 0..31.
  - Signed non-zero, not all-ones: out_q[31]!=out_q[30].
- Accumulator arithmetic:
  - amt is 5-bit unsigned.
  - The maximum sum is 31, so it never wraps.
- Handshake rules:
  - in_valid while not in IDLE is ignored; no latching and no side effects.
  - in_d and in_signed are only sampled at acceptance, so later changes do not affect the result.
- Reset mid-operation (RUN or DONE):
  - The operation is abandoned and all outputs go to their reset values immediately.
  - No result is ever emitted for an abandoned word.

Decomposition:
- Package shift_norm_pkg:
  - state_t enum {IDLE, RUN, DONE}
  - localparam NORM_UNSIGNED=1'b0, NORM_SIGNED=1'b1
  - localparam int STAGES=5
  - function stage_k(idx) returning 16>>idx
- Sub-module norm_stage (combinational): inputs work[31:0], k, signed_mode; outputs shifted word and take flag.
  - Instantiated once and reused each RUN cycle with k from the step index.
  - The top level holds the FSM, the step counter and the output registers.

Test Plan:
- Unsigned 32'h00000001 accepted at edge N:
  - out_valid rises after edge N+5.
  - out_q=32'h80000000, out_shift_amt=31, out_zero=0.
- Unsigned 32'h00F00000:
  - out_q=32'hF0000000, out_shift_amt=8.
  - Checker: barrel_shifter_32 with op=LSR and sh=8 returns 32'h00F00000.
- Signed 32'hFFFF8000:
  - out_q=32'h80000000, out_shift_amt=16.
- Signed 32'h00000000, then signed 32'hFFFFFFFF:
  - First result: out_zero=1, out_q=0, out_shift_amt=0.
  - Second result: out_zero=0, out_q=32'h80000000, out_shift_amt=31.
- Backpressure on unsigned 32'h12345678:
  - Hold out_ready=0 for 3 cycles after out_valid rises, and drive in_valid=1 with 32'hDEADBEEF during that time.
  - Outputs stay at out_q=32'h91A2B3C0, out_shift_amt=3.
  - in_ready=0 throughout, and the second word is not consumed.
- Reset mid-RUN:
  - Accept 32'h0000FFFF, then assert rst_n=0 at edge N+2.
  - All outputs go to 0 immediately.
  - After release, in_ready=1 and no out_valid appears for the abandoned word.
